// File: rtl/reset_sequencer.sv
// Board-level reset sequencer.
// A free-running prescaler produces a clock-enable tick. Three reset causes are
// merged: PLL lock loss, a debounced push button and a software request. Any
// cause asserts every channel at once. Once all causes are gone, the channels
// are held for a while and then released one at a time, lowest index first.
module reset_sequencer #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned PRESCALE       = 512,
    parameter int unsigned HOLD_TICKS     = 16,
    parameter int unsigned STAGGER_TICKS  = 4,
    parameter int unsigned DEBOUNCE_TICKS = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                pll_locked,
    input  logic                key_n,
    input  logic                sw_req,
    output logic [CHANNELS-1:0] rst_out,
    output logic                all_released,
    output logic                tick,
    output logic [1:0]          cause
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam int unsigned SW = $clog2(STAGGER_TICKS + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned IW = $clog2(CHANNELS + 1);

    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] HOLD_LAST     = HW'(HOLD_TICKS - 1);
    localparam logic [SW-1:0] STAGGER_LAST  = SW'(STAGGER_TICKS - 1);
    localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(CHANNELS - 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_PLL = 2'b01;
    localparam logic [1:0] CAUSE_KEY = 2'b10;
    localparam logic [1:0] CAUSE_SW  = 2'b11;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Synchroniser flops for the asynchronous inputs
    logic pll_meta;
    logic pll_sync;
    logic key_meta;
    logic key_sync;

    // Prescaler
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;

    // Debounce
    logic          key_pressed;
    logic [DW-1:0] deb_cnt;

    // Sequencer
    state_t              state;
    state_t              state_next;
    logic [HW-1:0]       hold_cnt;
    logic [HW-1:0]       hold_next;
    logic [SW-1:0]       stag_cnt;
    logic [SW-1:0]       stag_next;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_next;
    logic [CHANNELS-1:0] rst_next;
    logic [1:0]          cause_next;
    logic                all_released_next;

    logic       pll_lost;
    logic       cause_active;
    logic [1:0] cause_prio;

    // Two-flop synchronisers for PLL lock and the push button
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pll_meta <= 1'b0;
            pll_sync <= 1'b0;
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            pll_meta <= pll_locked;
            pll_sync <= pll_meta;
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    // Prescaler wrap value
    always_comb begin
        presc_next = (presc == PRESCALE_LAST) ? '0 : presc + PW'(1);
    end

    // Free-running prescaler; tick is registered and high while presc sits at its last value
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc_next;
            tick  <= (presc_next == PRESCALE_LAST);
        end
    end

    // Key debounce: flip only after enough consecutive disagreeing tick samples
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            key_pressed <= 1'b0;
            deb_cnt     <= '0;
        end else if (tick) begin
            if (!key_sync != key_pressed) begin
                if (deb_cnt == DEBOUNCE_LAST) begin
                    key_pressed <= ~key_pressed;
                    deb_cnt     <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Cause detection and priority encode (PLL > KEY > SW)
    always_comb begin
        pll_lost     = ~pll_sync;
        cause_active = pll_lost | key_pressed | sw_req;
        if (pll_lost) begin
            cause_prio = CAUSE_PLL;
        end else if (key_pressed) begin
            cause_prio = CAUSE_KEY;
        end else begin
            cause_prio = CAUSE_SW;
        end
    end

    // Sequencer next-state, counters and output values
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        stag_next  = stag_cnt;
        idx_next   = idx;
        rst_next   = rst_out;
        cause_next = cause;

        if (cause_active) begin
            state_next = ST_ASSERT;
            hold_next  = '0;
            stag_next  = '0;
            idx_next   = '0;
            rst_next   = '1;
            // cause is latched on entry into ASSERT; inside ASSERT only a lone sw_req may overwrite it
            if (state != ST_ASSERT) begin
                cause_next = cause_prio;
            end else if (sw_req && !pll_lost && !key_pressed) begin
                cause_next = CAUSE_SW;
            end
        end else begin
            case (state)
                ST_ASSERT: begin
                    rst_next = '1;
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_next = ST_RELEASE;
                            hold_next  = '0;
                            stag_next  = '0;
                            idx_next   = '0;
                        end else begin
                            hold_next = hold_cnt + HW'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (tick) begin
                        if (stag_cnt == STAGGER_LAST) begin
                            rst_next  = rst_out & ~(CHANNELS'(1) << idx);
                            idx_next  = idx + IW'(1);
                            stag_next = '0;
                            if (idx == IDX_LAST) begin
                                state_next = ST_RUN;
                            end
                        end else begin
                            stag_next = stag_cnt + SW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    rst_next = '0;
                end
                default: begin
                    state_next = ST_ASSERT;
                    rst_next   = '1;
                end
            endcase
        end

        all_released_next = (state_next == ST_RUN);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_ASSERT;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer counters and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold_cnt     <= '0;
            stag_cnt     <= '0;
            idx          <= '0;
            rst_out      <= '1;
            all_released <= 1'b0;
            cause        <= CAUSE_POR;
        end else begin
            hold_cnt     <= hold_next;
            stag_cnt     <= stag_next;
            idx          <= idx_next;
            rst_out      <= rst_next;
            all_released <= all_released_next;
            cause        <= cause_next;
        end
    end

endmodule
